// File: rtl/rrarb_wrr_sched_if.sv
// Requester-side bundle of the weighted round-robin scheduler: beat requests,
// per-requester weights, downstream ready and the registered ownership outputs.
interface rrarb_wrr_sched_if #(
    parameter int REQ_CNT = 4,
    parameter int IDX_W   = 2,
    parameter int WGT_W   = 4
) ();
    logic [REQ_CNT-1:0]       req;
    logic [REQ_CNT-1:0]       req_last;
    logic [REQ_CNT*WGT_W-1:0] weight;
    logic                     dn_ready;
    logic [REQ_CNT-1:0]       grant;
    logic [IDX_W-1:0]         grant_idx;
    logic                     busy;
    logic                     dn_valid;
    logic                     xfer;

    modport master (
        output req, req_last, weight, dn_ready,
        input  grant, grant_idx, busy, dn_valid, xfer
    );

    modport slave (
        input  req, req_last, weight, dn_ready,
        output grant, grant_idx, busy, dn_valid, xfer
    );
endinterface

// File: rtl/rrarb_wrr_sched.sv
// Weighted round-robin packet scheduler: an owner keeps the shared resource for
// wgt_lat packets, then ownership rotates with the released owner at lowest priority.
module rrarb_wrr_sched #(
    parameter int REQ_CNT = 4,
    parameter int IDX_W   = 2,
    parameter int WGT_W   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    rrarb_wrr_sched_if.slave    bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [REQ_CNT-1:0] grant_r;
    logic [REQ_CNT-1:0] grant_nxt_s;
    logic [IDX_W-1:0]   idx_r;
    logic [IDX_W-1:0]   idx_nxt_s;
    logic [IDX_W-1:0]   ptr_r;
    logic [IDX_W-1:0]   ptr_nxt_s;
    logic [WGT_W-1:0]   pkt_cnt_r;
    logic [WGT_W-1:0]   pkt_cnt_nxt_s;
    logic [WGT_W-1:0]   wgt_lat_r;
    logic [WGT_W-1:0]   wgt_lat_nxt_s;

    logic [IDX_W-1:0]   arb_base_s;
    logic               arb_found_s;
    logic [IDX_W-1:0]   arb_idx_s;
    logic               owner_beat_s;
    logic               pkt_end_s;
    logic               quota_done_s;
    logic               dn_valid_s;

    // First set request after base, wrapping; base itself is checked last.
    function automatic logic [IDX_W:0] rr_pick(
        input logic [REQ_CNT-1:0] r,
        input logic [IDX_W-1:0]   base
    );
        logic [IDX_W:0] res;
        int             raw;
        int             pos;
        res = {(IDX_W+1){1'b0}};
        for (int off = REQ_CNT; off >= 1; off--) begin
            raw = int'(base) + off;
            pos = (raw >= REQ_CNT) ? (raw - REQ_CNT) : raw;
            res = r[pos] ? {1'b1, IDX_W'(pos)} : res;
        end
        return res;
    endfunction

    // A programmed weight of zero still grants one packet per turn.
    function automatic logic [WGT_W-1:0] eff_weight(
        input logic [REQ_CNT*WGT_W-1:0] w,
        input logic [IDX_W-1:0]         i
    );
        logic [WGT_W-1:0] f;
        f = w[int'(i)*WGT_W +: WGT_W];
        return (f == WGT_W'(0)) ? WGT_W'(1) : f;
    endfunction

    // Arbitration and packet-boundary decode shared by the next-state logic.
    always_comb begin
        arb_base_s   = (state_r == ST_OWN) ? idx_r : ptr_r;
        {arb_found_s, arb_idx_s} = rr_pick(bus.req, arb_base_s);
        owner_beat_s = (state_r == ST_OWN) & bus.req[idx_r] & bus.dn_ready;
        pkt_end_s    = owner_beat_s & bus.req_last[idx_r];
        quota_done_s = pkt_end_s & ((pkt_cnt_r + WGT_W'(1)) == wgt_lat_r);
    end

    // State register: ownership, rotation pointer and per-turn packet count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            grant_r   <= {REQ_CNT{1'b0}};
            idx_r     <= {IDX_W{1'b0}};
            ptr_r     <= IDX_W'(REQ_CNT - 1);
            pkt_cnt_r <= {WGT_W{1'b0}};
            wgt_lat_r <= {WGT_W{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            grant_r   <= grant_nxt_s;
            idx_r     <= idx_nxt_s;
            ptr_r     <= ptr_nxt_s;
            pkt_cnt_r <= pkt_cnt_nxt_s;
            wgt_lat_r <= wgt_lat_nxt_s;
        end
    end

    // Next-state logic: grant from idle, count packets, hand over on quota.
    always_comb begin
        state_nxt_s   = state_r;
        grant_nxt_s   = grant_r;
        idx_nxt_s     = idx_r;
        ptr_nxt_s     = ptr_r;
        pkt_cnt_nxt_s = pkt_cnt_r;
        wgt_lat_nxt_s = wgt_lat_r;
        case (state_r)
            ST_IDLE: begin
                if (arb_found_s) begin
                    state_nxt_s   = ST_OWN;
                    grant_nxt_s   = REQ_CNT'(1) << arb_idx_s;
                    idx_nxt_s     = arb_idx_s;
                    pkt_cnt_nxt_s = WGT_W'(0);
                    wgt_lat_nxt_s = eff_weight(bus.weight, arb_idx_s);
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_OWN: begin
                if (quota_done_s) begin
                    // Handover in the same cycle keeps the resource fully used.
                    ptr_nxt_s = idx_r;
                    if (arb_found_s) begin
                        state_nxt_s   = ST_OWN;
                        grant_nxt_s   = REQ_CNT'(1) << arb_idx_s;
                        idx_nxt_s     = arb_idx_s;
                        pkt_cnt_nxt_s = WGT_W'(0);
                        wgt_lat_nxt_s = eff_weight(bus.weight, arb_idx_s);
                    end else begin
                        state_nxt_s   = ST_IDLE;
                        grant_nxt_s   = {REQ_CNT{1'b0}};
                        idx_nxt_s     = {IDX_W{1'b0}};
                        pkt_cnt_nxt_s = WGT_W'(0);
                        wgt_lat_nxt_s = WGT_W'(0);
                    end
                end else if (pkt_end_s) begin
                    pkt_cnt_nxt_s = pkt_cnt_r + WGT_W'(1);
                end else begin
                    pkt_cnt_nxt_s = pkt_cnt_r;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                grant_nxt_s   = {REQ_CNT{1'b0}};
                idx_nxt_s     = {IDX_W{1'b0}};
                ptr_nxt_s     = IDX_W'(REQ_CNT - 1);
                pkt_cnt_nxt_s = WGT_W'(0);
                wgt_lat_nxt_s = WGT_W'(0);
            end
        endcase
    end

    // Outputs: ownership straight from flops, beat handshake from the live grant.
    always_comb begin
        dn_valid_s    = |(bus.req & grant_r);
        bus.grant     = grant_r;
        bus.grant_idx = idx_r;
        bus.busy      = (state_r == ST_OWN);
        bus.dn_valid  = dn_valid_s;
        bus.xfer      = dn_valid_s & bus.dn_ready;
    end

endmodule

// File: doc/rrarb_wrr_sched.md
# rrarb_wrr_sched

Weighted round-robin packet scheduler that shares one downstream resource among REQ_CNT requesters. Ownership is granted per packet. A winner keeps the resource until it has sent `weight` packets, each ending with a `req_last` beat. Rotation then moves to the next requester in round-robin order. The block sits between the requester FIFOs and the shared output datapath mux, whose select is driven by `grant`.

## Interface
- REQ_CNT, 4: number of requesters, 2..16
- IDX_W, 2: width of grant_idx, equal to clog2(REQ_CNT)
- WGT_W, 4: width of each per-requester weight field
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  REQ_CNT  per-requester beat valid
- req_last  in  REQ_CNT  marks the final beat of a packet; meaningful only with req
- weight  in  REQ_CNT*WGT_W  quasi-static packets-per-turn, requester i at bits [i*WGT_W +: WGT_W]; value 0 treated as 1
- dn_ready  in  1  downstream accepts a beat this cycle
- grant  out  REQ_CNT  one-hot owner, registered
- grant_idx  out  IDX_W  binary index of the owner, registered; valid while busy
- busy  out  1  an owner exists, registered
- dn_valid  out  1  equal to |(req & grant)
- xfer  out  1  equal to dn_valid & dn_ready; a beat moves

## Operation
- State: busy/grant/grant_idx (owner), ptr (last released owner index), pkt_cnt (WGT_W bits), wgt_lat (weight latched at grant).
- Reset values: grant=0, grant_idx=0, busy=0, ptr=REQ_CNT-1 (requester 0 wins first), pkt_cnt=0, wgt_lat=0.
- IDLE (busy=0): if any req is set, pick the winner W = first set req scanning ptr+1, ptr+2, … with wrap modulo REQ_CNT. Next cycle: grant=onehot(W), grant_idx=W, busy=1, pkt_cnt=0, wgt_lat=max(weight[W],1).
- OWN (busy=1):
  - Owner beat = req[g] & dn_ready.
  - A beat with req_last[g]=1 ends a packet.
  - Packet end with pkt_cnt+1 < wgt_lat: pkt_cnt increments and the grant is held.
  - Packet end with pkt_cnt+1 == wgt_lat: release, and ptr<=g.
- Release cycle: re-arbitrate the same cycle using that cycle's req, scanning from g+1.
  - The current owner g has lowest priority but may win again if it is the only requester.
  - A winner is granted on the next cycle, back-to-back with no idle cycle.
  - If there is no winner, grant=0 and busy=0 on the next cycle.
- The lock is unconditional. Dropping req[g] mid-packet only stalls, and the owner keeps the grant. Requests from non-owners never preempt.
- req_last on a non-owner, or without req, is ignored.
- A weight change while owning has no effect until the next grant, because wgt_lat is latched at grant.
- pkt_cnt never wraps, since release occurs at wgt_lat ≤ 2^WGT_W-1.
- grant is always one-hot or zero; grant_idx equals the encoded grant whenever busy=1.

## Timing
- Arbitration latency: req rising in IDLE at cycle t gives grant at t+1. The first xfer is possible at t+1.
- Handover: the final last-beat xfer at cycle t gives the new owner at t+1. 100% throughput is sustainable across owners.
- dn_valid and xfer are combinational from req/dn_ready and the registered grant, so there is no added latency.
- The asynchronous reset mid-packet clears all state immediately. The first post-reset grant goes to the lowest-index requester.
- Single requester with weight W: it is granted continuously; release and re-grant to itself happen with no gap.

## Test plan
- Reset, then req=4'b1010, all weights=1, dn_ready=1, one-beat packets (req_last=req) -> grants 1,3,1,3… on consecutive cycles, xfer=1 every cycle, busy=1 throughout.
- req=4'b1111, weights {3,1,2,0}, one-beat packets, dn_ready=1 -> grant_idx sequence 0,0,0,1,2,2,3,0,0,0…; weight 0 behaves as 1.
- Owner 2 sends a 4-beat packet, dn_ready toggling 1,0,1,0…, req[2] dropped one cycle mid-packet, req[0] asserted throughout -> grant stays 4'b0100 until the last beat xfers; grant 4'b0001 the next cycle.
- Only req[3] with weight 2 and 2-beat packets -> grant 4'b1000 is never deasserted; pkt_cnt goes 0→1→0 (release/re-grant); busy stays 1.
- Last beat of the owner, all other req=0, owner req=0 on the release cycle -> grant=0 and busy=0 on the next cycle; a new req[1] two cycles later gives grant 4'b0010 one cycle after.
- rst_n asserted mid-packet while owner=2 -> grant=0 and busy=0 immediately; after release with req=4'b0110 -> grant 4'b0010 first.
